// File: rtl/avg_pkg.sv
// Shared types for the vector-generator fetch sequencer: opcodes, FSM states
// and the command payload handed to the beam stage.
package avg_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_VCTR = 3'd0,
    OP_HALT = 3'd1,
    OP_SVEC = 3'd2,
    OP_STAT = 3'd3,
    OP_CNTR = 3'd4,
    OP_JSR  = 3'd5,
    OP_RTS  = 3'd6,
    OP_JMP  = 3'd7
  } avg_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_DEC  = 3'd2,
    S_RD1  = 3'd3,
    S_CAP1 = 3'd4,
    S_EMIT = 3'd5
  } avg_state_e;

  typedef struct packed {
    avg_op_e             op;
    logic [WORD_W-1:0]   w0;
    logic [WORD_W-1:0]   w1;
  } avg_cmd_t;

endpackage

// File: rtl/avg_ret_stack.sv
// Return-address LIFO for JSR/RTS. Top, full and empty are held in registers
// so the sequencer sees them without a read-mux path through the array.
module avg_ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [W-1:0]    top_q;
  logic            full_q;
  logic            empty_q;

  // Overflowing push / underflowing pop are ignored; the caller flags them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      top_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      sp_q    <= '0;
      top_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (push_i && !full_q) begin
      mem_q[IDX_W'(sp_q)] <= push_data_i;
      sp_q    <= sp_q + SP_W'(1);
      top_q   <= push_data_i;
      empty_q <= 1'b0;
      full_q  <= (sp_q == SP_W'(DEPTH - 1));
    end else if (pop_i && !empty_q) begin
      sp_q    <= sp_q - SP_W'(1);
      full_q  <= 1'b0;
      empty_q <= (sp_q == SP_W'(1));
      top_q   <= (sp_q >= SP_W'(2)) ? mem_q[IDX_W'(sp_q - SP_W'(2))] : '0;
    end
  end

  assign top_o   = top_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/avg_fetch_seq.sv
// Vector-generator display-list sequencer: fetches 16-bit words, resolves
// flow control internally and streams drawing commands over valid/ready.
module avg_fetch_seq
  import avg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned MAX_INSTR   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vggo,
  input  logic              vgrst,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [15:0]       cmd_w0,
  output logic [15:0]       cmd_w1,
  output logic              halt,
  output logic              err_stack,
  output logic              err_loop
);

  localparam int unsigned CNT_W = $clog2(MAX_INSTR + 1);

  avg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  avg_cmd_t          cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              halt_q, halt_d;
  logic              err_stack_q, err_stack_d;
  logic              err_loop_q, err_loop_d;

  logic              stk_clr, stk_push, stk_pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;
  avg_op_e           dec_op;

  avg_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (stk_clr),
    .push_i      (stk_push),
    .pop_i       (stk_pop),
    .push_data_i (pc_q),
    .top_o       (stk_top),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      halt_q      <= 1'b1;
      err_stack_q <= 1'b0;
      err_loop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      halt_q      <= halt_d;
      err_stack_q <= err_stack_d;
      err_loop_q  <= err_loop_d;
    end
  end

  // Next state and next registered outputs; read strobe/address are decided
  // one cycle ahead so they appear registered in RD0/RD1.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    halt_d      = halt_q;
    err_stack_d = err_stack_q;
    err_loop_d  = err_loop_q;
    stk_clr     = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    dec_op      = avg_op_e'(rd_data[15:13]);

    case (state_q)
      S_IDLE: begin
        halt_d = 1'b1;
        if (vggo) begin
          pc_d        = '0;
          cnt_d       = '0;
          err_stack_d = 1'b0;
          err_loop_d  = 1'b0;
          halt_d      = 1'b0;
          stk_clr     = 1'b1;
          state_d     = S_RD0;
        end
      end
      S_RD0: begin
        pc_d    = pc_q + ADDR_W'(1);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_DEC;
      end
      S_DEC: begin
        cmd_d.op = dec_op;
        cmd_d.w0 = rd_data;
        cmd_d.w1 = '0;
        case (dec_op)
          OP_VCTR: state_d = S_RD1;
          OP_HALT: state_d = S_IDLE;
          OP_SVEC, OP_STAT, OP_CNTR: begin
            cmd_valid_d = 1'b1;
            state_d     = S_EMIT;
          end
          OP_JMP: begin
            pc_d    = rd_data[ADDR_W-1:0];
            state_d = S_RD0;
          end
          OP_JSR: begin
            if (stk_full) begin
              err_stack_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              stk_push = 1'b1;
              pc_d     = rd_data[ADDR_W-1:0];
              state_d  = S_RD0;
            end
          end
          OP_RTS: begin
            if (stk_empty) begin
              err_stack_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
              state_d = S_RD0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_RD1: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_CAP1;
      end
      S_CAP1: begin
        cmd_d.w1    = rd_data;
        cmd_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_RD0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog: refuse a further instruction fetch once the budget is spent.
    if (state_d == S_RD0 && state_q != S_IDLE && cnt_q >= CNT_W'(MAX_INSTR)) begin
      err_loop_d = 1'b1;
      state_d    = S_IDLE;
    end

    if (state_d == S_IDLE) halt_d = 1'b1;

    if (state_d == S_RD0 || state_d == S_RD1) begin
      rd_en_d   = 1'b1;
      rd_addr_d = pc_d;
    end

    // Abort wins over everything, including a same-cycle start; errors survive.
    if (vgrst) begin
      state_d     = S_IDLE;
      cmd_valid_d = 1'b0;
      rd_en_d     = 1'b0;
      halt_d      = 1'b1;
      err_stack_d = err_stack_q;
      err_loop_d  = err_loop_q;
      stk_clr     = 1'b1;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_q.op;
  assign cmd_w0    = cmd_q.w0;
  assign cmd_w1    = cmd_q.w1;
  assign halt      = halt_q;
  assign err_stack = err_stack_q;
  assign err_loop  = err_loop_q;

endmodule
